// File: rtl/dds_pkg.sv
// Shared constants, waveform encodings and the quarter-wave sine table generator
// for the DDS phase-to-amplitude stage.
package dds_pkg;

    localparam int PHASE_W = 8;
    localparam int OUT_W   = 8;
    localparam int QTR_AW  = 6;

    localparam logic [7:0] MIDSCALE = 8'd128;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_TRI    = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_SQUARE = 2'd3
    } wave_t;

    // Q[k] = round(127 * sin(2*pi*(k+0.5)/256)), via a Taylor series so it folds to a constant.
    function automatic logic [6:0] qtr_sine(input int k);
        real x;
        real term;
        real sum;
        x    = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / 256.0;
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            sum  = sum + term;
        end
        return 7'($rtoi(127.0 * sum + 0.5));
    endfunction

endpackage

// File: rtl/dds_quarter_sine_rom.sv
// 64x7 quarter-wave sine ROM with a registered read port.
module dds_quarter_sine_rom
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic [QTR_AW-1:0] addr,
    output logic [6:0]        data
);

    logic [6:0] rom_tbl [0:(1 << QTR_AW) - 1];

    for (genvar gi = 0; gi < (1 << QTR_AW); gi++) begin : g_rom
        localparam logic [6:0] ROM_VAL = qtr_sine(gi);
        assign rom_tbl[gi] = ROM_VAL;
    end

    always_ff @(posedge clk) begin
        data <= rom_tbl[addr];
    end

endmodule

// File: rtl/dds_phase_to_amp.sv
// Phase word to amplitude sample: wrap-synchronised waveform select, raw waveform
// generation and amplitude scaling about mid-scale.
module dds_phase_to_amp
    import dds_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   phase_in,
    input  logic         phase_valid,
    input  logic [1:0]   wave_sel,
    input  logic [7:0]   amp,
    output logic [7:0]   sample_out,
    output logic         sample_valid,
    output logic [1:0]   wave_active
);

    logic [7:0] prev_phase_reg;
    logic       first_reg;
    logic [7:0] phase1_reg;
    logic [7:0] amp1_reg;
    logic       v1_reg;
    logic [1:0] wave_active_reg;
    logic       wrap;

    assign wrap        = first_reg || (phase_in < prev_phase_reg);
    assign wave_active = wave_active_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_phase_reg  <= '0;
            first_reg       <= 1'b1;
            phase1_reg      <= '0;
            amp1_reg        <= '0;
            v1_reg          <= 1'b0;
            wave_active_reg <= WAVE_SINE;
        end else begin
            v1_reg <= phase_valid;
            if (phase_valid) begin
                phase1_reg     <= phase_in;
                amp1_reg       <= amp;
                prev_phase_reg <= phase_in;
                if (wrap) begin
                    wave_active_reg <= wave_sel;
                    first_reg       <= 1'b0;
                end
            end
        end
    end

    // Odd quadrants read the table mirrored: 63-i is simply ~i on six bits.
    logic [QTR_AW-1:0] rom_addr;
    logic [6:0]        rom_data;

    assign rom_addr = phase1_reg[6] ? ~phase1_reg[5:0] : phase1_reg[5:0];

    dds_quarter_sine_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    logic [7:0] alt2_reg;
    logic [7:0] amp2_reg;
    logic [1:0] wave2_reg;
    logic       neg2_reg;
    logic       v2_reg;
    logic [7:0] alt_next;

    always_comb begin
        alt_next = '0;
        case (wave_active_reg)
            WAVE_TRI:    alt_next = phase1_reg[7] ? ~{phase1_reg[6:0], 1'b0} : {phase1_reg[6:0], 1'b0};
            WAVE_SAW:    alt_next = phase1_reg;
            WAVE_SQUARE: alt_next = phase1_reg[7] ? 8'd0 : 8'd255;
            default:     alt_next = '0;
        endcase
    end

    // wave_active still holds this sample's waveform here: a newer wrap only lands on this same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alt2_reg  <= '0;
            amp2_reg  <= '0;
            wave2_reg <= WAVE_SINE;
            neg2_reg  <= 1'b0;
            v2_reg    <= 1'b0;
        end else begin
            alt2_reg  <= alt_next;
            amp2_reg  <= amp1_reg;
            wave2_reg <= wave_active_reg;
            neg2_reg  <= phase1_reg[7];
            v2_reg    <= v1_reg;
        end
    end

    logic [7:0] raw3_reg;
    logic [7:0] amp3_reg;
    logic       v3_reg;
    logic [7:0] sine_raw;

    assign sine_raw = neg2_reg ? (8'd127 - {1'b0, rom_data}) : (MIDSCALE + {1'b0, rom_data});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw3_reg <= MIDSCALE;
            amp3_reg <= '0;
            v3_reg   <= 1'b0;
        end else begin
            raw3_reg <= (wave2_reg == WAVE_SINE) ? sine_raw : alt2_reg;
            amp3_reg <= amp2_reg;
            v3_reg   <= v2_reg;
        end
    end

    logic signed [9:0]  diff;
    logic signed [9:0]  gain;
    logic signed [19:0] prod;
    logic signed [9:0]  scaled;

    assign diff   = $signed({2'b00, raw3_reg}) - 10'sd128;
    assign gain   = $signed({2'b00, amp3_reg}) + 10'sd1;
    assign prod   = diff * gain;
    assign scaled = 10'(prod >>> 8);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_out   <= MIDSCALE;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= v3_reg;
            if (v3_reg) begin
                sample_out <= 8'(scaled + 10'sd128);
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_to_amp.sv
// Scoreboard bench for dds_phase_to_amp: a driver models the expected samples,
// a negedge monitor compares value, latency, hold behaviour and wave_active.
module tb_dds_phase_to_amp;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] phase_in = '0;
    logic       phase_valid = 1'b0;
    logic [1:0] wave_sel = '0;
    logic [7:0] amp = '0;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic [1:0] wave_active;

    dds_phase_to_amp dut (
        .clk          (clk),
        .reset        (reset),
        .phase_in     (phase_in),
        .phase_valid  (phase_valid),
        .wave_sel     (wave_sel),
        .amp          (amp),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .wave_active  (wave_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int value;
        int due;
        int phase;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_exp = 128;
    int   m_prev = 0;
    bit   m_first = 1'b1;
    int   m_active = 0;
    bit   done = 1'b0;
    bit   drained = 1'b0;

    function automatic int qv(int k);
        return $rtoi(127.0 * $sin(2.0 * 3.14159265358979323846 * (k + 0.5) / 256.0) + 0.5);
    endfunction

    function automatic int ref_sample(int p, int w, int a);
        int raw;
        int i;
        i = p % 64;
        case (w)
            0: case (p / 64)
                   0: raw = 128 + qv(i);
                   1: raw = 128 + qv(63 - i);
                   2: raw = 127 - qv(i);
                   default: raw = 127 - qv(63 - i);
               endcase
            1: raw = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            2: raw = p;
            default: raw = (p < 128) ? 255 : 0;
        endcase
        return 128 + (((raw - 128) * (a + 1)) >>> 8);
    endfunction

    task automatic step(input int p, input bit v, input int w, input int a);
        exp_t e;
        phase_in    = 8'(p);
        phase_valid = v;
        wave_sel    = 2'(w);
        amp         = 8'(a);
        @(posedge clk);
        #1;
        if (v) begin
            if (m_first || p < m_prev) begin
                m_active = w;
                m_first  = 1'b0;
            end
            m_prev  = p;
            e.value = ref_sample(p, m_active, a);
            e.due   = cyc + 3;
            e.phase = p;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b0;
        exp_q.delete();
        m_first  = 1'b1;
        m_prev   = 0;
        m_active = 0;
        last_exp = 128;
        phase_valid = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done && !drained) begin
            drained = 1'b1;
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d samples never appeared, required 0", exp_q.size());
            end
        end else if (!reset) begin
            n_cmp++;
            if (sample_valid !== 1'b0 || sample_out !== 8'd128 || wave_active !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state: valid=%0b out=%0d wave=%0d, required 0/128/0",
                         sample_valid, sample_out, wave_active);
            end
        end else begin
            n_cmp++;
            if (wave_active !== 2'(m_active)) begin
                n_fail++;
                $display("FAIL wave_active: got %0d, required %0d", wave_active, m_active);
            end
            if (sample_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_sample: got %0d at cycle %0d, required no sample", sample_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e.value;
                    if (sample_out !== 8'(e.value) || cyc != e.due) begin
                        n_fail++;
                        $display("FAIL sample phase=%0d: got %0d at cycle %0d, required %0d at cycle %0d",
                                 e.phase, sample_out, cyc, e.value, e.due);
                    end else begin
                        $display("sample phase=%0d out=%0d cycle=%0d ok", e.phase, sample_out, cyc);
                    end
                end
            end else if (sample_out !== 8'(last_exp)) begin
                n_fail++;
                $display("FAIL hold: got %0d, required %0d", sample_out, last_exp);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);

        // sine at the four quadrant starts: 130, 255, 125, 0
        step(0, 1, 0, 255);
        step(64, 1, 0, 255);
        step(128, 1, 0, 255);
        step(192, 1, 0, 255);

        // triangle: 0, 254, 255, 1
        step(0, 1, 1, 255);
        step(127, 1, 1, 255);
        step(128, 1, 1, 255);
        step(255, 1, 1, 255);

        // square: 255, 0
        step(10, 1, 3, 255);
        step(200, 1, 3, 255);

        // saw scaling: 64, 191, 127
        step(0, 1, 2, 127);
        step(255, 1, 2, 127);
        step(0, 1, 2, 0);

        // waveform switch only at the 240 -> 0 wrap
        for (int k = 0; k < 16; k++) step(k * 16, 1, (k >= 3) ? 3 : 2, 255);
        step(0, 1, 3, 255);
        step(16, 1, 3, 255);

        // bubbles
        step(20, 1, 2, 255);
        step(40, 0, 2, 255);
        step(60, 1, 2, 255);
        step(80, 0, 2, 255);
        step(90, 0, 2, 255);
        step(100, 1, 2, 255);

        // random stimulus
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 255), ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                 $urandom_range(0, 255));
        end

        // reset with three samples in flight, asserted between edges
        step(30, 1, 1, 200);
        step(60, 1, 1, 200);
        step(90, 1, 1, 200);
        do_reset(2);
        step(50, 1, 2, 255);
        step(70, 1, 2, 128);
        step(20, 1, 0, 255);

        for (int k = 0; k < 60; k++) begin
            step($urandom_range(0, 255), 1'b1, $urandom_range(0, 3), $urandom_range(0, 255));
        end

        phase_valid = 1'b0;
        repeat (6) @(posedge clk);
        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
